// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter granting a single dig slot to one of N lemmings at a time.
// Each grant is bounded to MAX_DIG cycles and is followed by a COOLDOWN gap.
module lemming_dig_arbiter #(
  parameter int N        = 4,
  parameter int MAX_DIG  = 16,
  parameter int COOLDOWN = 2,
  localparam int ID_W    = $clog2(N)
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    done,
  input  logic            abort,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam int DIG_W  = (MAX_DIG  > 1) ? $clog2(MAX_DIG)  : 1;
  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DIG_W-1:0]  cnt_q, cnt_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [N-1:0]      gnt_d;
  logic [ID_W-1:0]   gnt_id_d;
  logic              timeout_d;

  // Rotate req so that bit 0 is the lemming at the round-robin pointer.
  logic [N-1:0]      req_rot;
  logic [ID_W-1:0]   pick;
  int                pick_off;
  int                pick_sum;

  assign req_rot = N'({req, req} >> ptr_q);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pick_off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = k;
    end
    pick_sum = int'(ptr_q) + pick_off;
    if (pick_sum >= N) pick_sum = pick_sum - N;
    pick = ID_W'(pick_sum);
  end

  logic early_release;
  logic expired;

  assign early_release = done[gnt_id] | ~req[gnt_id] | abort;
  assign expired       = (cnt_q == DIG_W'(MAX_DIG - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    cool_d    = cool_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req && !abort) begin
          state_d  = S_GRANT;
          gnt_d    = N'(1) << pick;
          gnt_id_d = pick;
          cnt_d    = '0;
        end
      end
      S_GRANT: begin
        if (early_release || expired) begin
          state_d   = S_COOL;
          gnt_d     = '0;
          ptr_d     = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
          cool_d    = '0;
          // Only a pure expiry is reported; any coincident cause masks it.
          timeout_d = expired && !early_release;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COOL: begin
        if (cool_q == COOL_W'(COOLDOWN - 1)) state_d = S_IDLE;
        else                                  cool_d  = cool_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      cool_q  <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= (state_d != S_IDLE);
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Self-checking bench for lemming_dig_arbiter: directed scenarios plus random
// traffic compared every cycle against a grant-ownership model.
module tb_lemming_dig_arbiter;

  localparam int N        = 4;
  localparam int MAX_DIG  = 16;
  localparam int COOLDOWN = 2;
  localparam int ID_W     = $clog2(N);

  logic            clk = 1'b0;
  logic            areset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    done = '0;
  logic            abort = 1'b0;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  int n_pass  = 0;
  int n_total = 0;

  lemming_dig_arbiter #(.N(N), .MAX_DIG(MAX_DIG), .COOLDOWN(COOLDOWN)) dut (
    .clk(clk), .areset_n(areset_n), .req(req), .done(done), .abort(abort),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the slot, for how many cycles, and how much gap remains.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_tmo   = 1'b0;

  task automatic model_step();
    bit early;
    if (!areset_n) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        early = done[ID_W'(m_owner)] || !req[ID_W'(m_owner)] || abort;
        if (early || m_held == MAX_DIG) begin
          m_tmo   = !early;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = COOLDOWN;
        end else begin
          m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != '0 && !abort) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[ID_W'((m_ptr + k) % N)]) begin
            m_owner = (m_ptr + k) % N;
            m_last  = m_owner;
            m_held  = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge areset_n) model_step();

  // Per-cycle comparison, one time unit after the edge.
  always @(posedge clk) begin
    #1;
    check("gnt",     32'(gnt),     (m_owner >= 0) ? (32'(1) << m_owner) : 32'(0));
    check("gnt_id",  32'(gnt_id),  32'(m_last));
    check("busy",    32'(busy),    32'((m_owner >= 0) || (m_gap > 0)));
    check("timeout", 32'(timeout), 32'(m_tmo));
    check("onehot",  32'($countones(gnt) <= 1), 32'(1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    while (gnt == '0 && cycles < 100) begin
      step();
      cycles++;
    end
    check("wait_grant_bound", 32'(cycles < 100), 32'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("wait_idle_bound", 32'(n < 100), 32'(1));
  endtask

  int gap;
  int hi;
  logic [N-1:0] flip;

  initial begin
    // 1: reset hold, then first grant to index 0
    req = 4'b1111;
    repeat (3) step();
    check("t1_rst_gnt", 32'(gnt), 32'(0));
    check("t1_rst_busy", 32'(busy), 32'(0));
    check("t1_rst_tmo", 32'(timeout), 32'(0));
    check("t1_rst_id", 32'(gnt_id), 32'(0));
    areset_n = 1'b1;
    step();
    check("t1_first_gnt", 32'(gnt), 32'(4'b0001));
    check("t1_model_pin", 32'(m_owner), 32'(0));
    req = '0;
    step();
    wait_idle();

    // 2: single request, done in 3rd grant cycle
    req = 4'b0100;
    step();
    check("t2_gnt", 32'(gnt), 32'(4'b0100));
    repeat (2) step();
    done = 4'b0100;
    step();
    done = '0;
    check("t2_release", 32'(gnt), 32'(0));
    check("t2_busy1", 32'(busy), 32'(1));
    req = '0;
    step();
    check("t2_busy2", 32'(busy), 32'(1));
    step();
    check("t2_idle", 32'(busy), 32'(0));

    // 3: round-robin from a fresh reset
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        gap = 0;
        while (gnt == '0 && gap < 50) begin
          gap++;
          step();
        end
        check("t3_gap", 32'(gap), 32'(COOLDOWN + 1));
      end
      check("t3_order", 32'(gnt), 32'(1) << (k % N));
      done = gnt;
      step();
      done = '0;
    end

    // 4: timeout after exactly MAX_DIG cycles, next grant goes to 2
    req = 4'b0010;
    wait_grant(gap);
    check("t4_gnt", 32'(gnt), 32'(4'b0010));
    hi = 0;
    while (gnt == 4'b0010 && hi < 40) begin
      hi++;
      step();
    end
    check("t4_len", 32'(hi), 32'(16));
    check("t4_timeout", 32'(timeout), 32'(1));
    check("t4_model_tmo", 32'(m_tmo), 32'(1));
    req = 4'b0110;
    wait_grant(gap);
    check("t4_next", 32'(gnt), 32'(4'b0100));

    // 5a: done coincides with expiry -> no timeout pulse
    repeat (15) step();
    done = 4'b0100;
    step();
    done = '0;
    check("t5a_gnt", 32'(gnt), 32'(0));
    check("t5a_tmo", 32'(timeout), 32'(0));

    // 5b: abort in grant cycle 5
    wait_grant(gap);
    check("t5b_gnt", 32'(gnt), 32'(4'b0010));
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5b_rel", 32'(gnt), 32'(0));
    check("t5b_tmo", 32'(timeout), 32'(0));

    // 6: asynchronous reset mid-grant of index 3
    req = 4'b1000;
    wait_grant(gap);
    check("t6_gnt", 32'(gnt), 32'(4'b1000));
    step();
    #2;
    areset_n = 1'b0;
    #1;
    check("t6_async_gnt", 32'(gnt), 32'(0));
    check("t6_async_tmo", 32'(timeout), 32'(0));
    step();
    areset_n = 1'b1;
    step();
    check("t6_regrant", 32'(gnt), 32'(4'b1000));
    check("t6_id", 32'(gnt_id), 32'(3));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
      req   = req ^ flip;
      for (int b = 0; b < N; b++) done[b] = ($urandom_range(0, 11) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if (!areset_n) areset_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) areset_n = 1'b0;
      step();
    end
    areset_n = 1'b1;
    req = '0; done = '0; abort = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
